alu_seq_ctrl: RTL
=================

// Module: alu_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer in front of the combinational 16-bit ALU (ALU_toplevel).
//  - Owns an 8x16 register file and accepts register-to-register commands over a valid/ready handshake.
//  - Drives ALU FS/A/B, captures out and zero_flag, and writes the result back.
//  - Sits between the instruction/decoder layer and the ALU datapath.
// PARAMETERS
//  NBIT   16  datapath width; must match the ALU nBit
//  NREG   8   register file depth (power of 2)
//  AW     3   register address width, = log2(NREG)
// PORTS
//  clk        in   1     single system clock, rising edge
//  rst        in   1     synchronous reset, active-high
//  cmd_valid  in   1     command offered
//  cmd_ready  out  1     command accepted when cmd_valid & cmd_ready
//  cmd_fs     in   3     ALU function select, passed unchanged to ALU FS
//  cmd_rd     in   AW    destination register
//  cmd_ra     in   AW    operand A register
//  cmd_rb     in   AW    operand B register
//  ld_valid   in   1     immediate load request (write ld_data to ld_rd)
//  ld_rd      in   AW    load destination
//  ld_data    in   NBIT  load value
//  alu_fs     out  3     to ALU FS
//  alu_a      out  NBIT  to ALU A
//  alu_b      out  NBIT  to ALU B
//  alu_out    in   NBIT  from ALU out
//  alu_zero   in   1     from ALU zero_flag
//  done       out  1     one-cycle pulse: result written back
//  res_data   out  NBIT  last written result; held until next done
//  zero       out  1     registered ALU zero flag of the last command
//  dbg_addr   in   AW    debug read address
//  dbg_data   out  NBIT  regfile[dbg_addr], combinational
// BEHAVIOUR
//  - Reset: state=IDLE, all regs=0, alu_fs/alu_a/alu_b=0, done=0, res_data=0, zero=0.
//    cmd_ready=0 during the reset cycle.
//  - FSM IDLE->READ->EXEC->WB->IDLE.
//    - cmd_ready=1 only in IDLE and only when ld_valid=0.
//  - IDLE: on accept, latch fs/rd/ra/rb -> READ.
//    - ld_valid in IDLE writes ld_data to reg[ld_rd] next edge.
//    - Load has priority over cmd the same cycle; the cmd waits.
//  - READ: register alu_fs=fs, alu_a=reg[ra], alu_b=reg[rb] -> EXEC.
//  - EXEC: ALU settles; capture alu_out into res_tmp and alu_zero into zero_tmp -> WB.
//  - WB: reg[rd]<=res_tmp, res_data<=res_tmp, zero<=zero_tmp, done=1 -> IDLE.
//  - Latency: accept at edge N gives done high in cycle N+3 and the reg updated at edge N+3.
//    Throughput is 1 cmd per 4 cycles.
//  - alu_fs/alu_a/alu_b hold their values outside READ (no glitching between commands).
//  - ld_valid outside IDLE is ignored and dropped. The requester must see cmd_ready/IDLE; no buffering.
//  - rd==ra or rd==rb: operands are sampled in READ, so the old value is used; the write happens in WB.
//  - Back-to-back dependent cmds see the prior result, since WB completes before the next READ.
//  - Arithmetic is NBIT-wide and wraps; carry is not exposed. zero is the ALU flag verbatim, not recomputed.
//  - rst in any state: abort the op, no writeback, done=0, all regs cleared.
// STRUCTURE
//  - Shared package alu_pkg:
//    - FS constants: FS_ADD=3'b000, FS_SUB=3'b001, FS_AND=3'b010, FS_OR=3'b011,
//      FS_XOR=3'b100, FS_NOT=3'b101 (110/111 alias AND/OR).
//    - State encoding: IDLE=0, READ=1, EXEC=2, WB=3.
//  - One sub-module, alu_regfile (NREG x NBIT):
//    - 1 sync write port with ld/wb mux outside.
//    - 3 async read ports: ra, rb, dbg.
//  - The ALU itself is instantiated by the parent, not inside this block.
// TESTING
//  1. Reset then dbg read of all regs -> all 0. done=0, cmd_ready=1 the cycle after rst drops.
//  2. ld r1=0x0005, ld r2=0x0003; cmd ADD r3=r1+r2 -> done 3 cycles after accept, r3=0x0008, res_data=0x0008.
//  3. SUB r4=r1-r1 (with the real ALU) -> r4=0x0000, zero=1. ADD 0xFFFF+0x0001 -> 0x0000, wrap.
//  4. ld_valid and cmd_valid in the same IDLE cycle -> load written, cmd_ready=0. Cmd accepted next cycle.
//  5. Dependent chain: NOT r5=~r1, then AND r6=r5&r2 -> r5=0xFFFA, r6=0x0002. Also ld_valid during EXEC -> ignored.
//  6. rst asserted in EXEC -> no done pulse, destination reg stays 0, FSM in IDLE after release.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the ALU sequencer: sizes, function selects, FSM states
package alu_pkg;

   localparam int ALU_NBIT = 16;
   localparam int ALU_NREG = 8;
   localparam int ALU_AW   = 3;

   // 3'b110 and 3'b111 alias AND and OR inside the ALU itself
   localparam logic [2:0] FS_ADD = 3'b000;
   localparam logic [2:0] FS_SUB = 3'b001;
   localparam logic [2:0] FS_AND = 3'b010;
   localparam logic [2:0] FS_OR  = 3'b011;
   localparam logic [2:0] FS_XOR = 3'b100;
   localparam logic [2:0] FS_NOT = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_e;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - command handshake and immediate-load request bundle
interface alu_seq_ctrl_if
   import alu_pkg::*;
#(
   parameter int NBIT = ALU_NBIT,
   parameter int AW   = ALU_AW
) ();

   logic            cmd_valid;
   logic            cmd_ready;
   logic [2:0]      cmd_fs;
   logic [AW-1:0]   cmd_rd;
   logic [AW-1:0]   cmd_ra;
   logic [AW-1:0]   cmd_rb;
   logic            ld_valid;
   logic [AW-1:0]   ld_rd;
   logic [NBIT-1:0] ld_data;

   modport master (
      output cmd_valid, cmd_fs, cmd_rd, cmd_ra, cmd_rb,
      output ld_valid, ld_rd, ld_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_fs, cmd_rd, cmd_ra, cmd_rb,
      input  ld_valid, ld_rd, ld_data,
      output cmd_ready
   );

endinterface

// File: rtl/alu_seq_ctrl_regfile.sv
// rtl/alu_seq_ctrl_regfile.sv - NREG x NBIT register file, one sync write port, three async read ports
module alu_regfile
   import alu_pkg::*;
#(
   parameter int NBIT = ALU_NBIT,
   parameter int NREG = ALU_NREG,
   parameter int AW   = ALU_AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [NBIT-1:0] wdata_i,
   input  logic [AW-1:0]   ra_addr_i,
   output logic [NBIT-1:0] ra_data_o,
   input  logic [AW-1:0]   rb_addr_i,
   output logic [NBIT-1:0] rb_data_o,
   input  logic [AW-1:0]   dbg_addr_i,
   output logic [NBIT-1:0] dbg_data_o
);

   logic [NBIT-1:0] mem_q [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign ra_data_o  = mem_q[ra_addr_i];
   assign rb_data_o  = mem_q[rb_addr_i];
   assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - four-state sequencer driving an external combinational ALU from a register file
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int NBIT = ALU_NBIT,
   parameter int NREG = ALU_NREG,
   parameter int AW   = ALU_AW
) (
   input  logic             clk,
   input  logic             rst,
   alu_seq_ctrl_if.slave    req,
   output logic [2:0]       alu_fs,
   output logic [NBIT-1:0]  alu_a,
   output logic [NBIT-1:0]  alu_b,
   input  logic [NBIT-1:0]  alu_out,
   input  logic             alu_zero,
   output logic             done,
   output logic [NBIT-1:0]  res_data,
   output logic             zero,
   input  logic [AW-1:0]    dbg_addr,
   output logic [NBIT-1:0]  dbg_data
);

   state_e          state_q;
   logic [2:0]      fs_q;
   logic [AW-1:0]   rd_q;
   logic [AW-1:0]   ra_q;
   logic [AW-1:0]   rb_q;
   logic [2:0]      alu_fs_q;
   logic [NBIT-1:0] alu_a_q;
   logic [NBIT-1:0] alu_b_q;
   logic [NBIT-1:0] res_tmp_q;
   logic            zero_tmp_q;
   logic            done_q;
   logic [NBIT-1:0] res_data_q;
   logic            zero_q;

   logic            cmd_ready_d;
   logic            accept_d;
   logic            rf_we_d;
   logic [AW-1:0]   rf_waddr_d;
   logic [NBIT-1:0] rf_wdata_d;
   logic [NBIT-1:0] rf_a;
   logic [NBIT-1:0] rf_b;

   // A pending load blocks the command so both never compete for the write port
   assign cmd_ready_d = !rst && (state_q == ST_IDLE) && !req.ld_valid;
   assign accept_d    = req.cmd_valid && cmd_ready_d;
   assign req.cmd_ready = cmd_ready_d;

   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = req.ld_rd;
      rf_wdata_d = req.ld_data;
      if (state_q == ST_WB) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = rd_q;
         rf_wdata_d = res_tmp_q;
      end else if (state_q == ST_IDLE && req.ld_valid) begin
         rf_we_d    = 1'b1;
      end
   end

   alu_regfile #(
      .NBIT (NBIT),
      .NREG (NREG),
      .AW   (AW)
   ) u_regfile (
      .clk        (clk),
      .rst        (rst),
      .we_i       (rf_we_d),
      .waddr_i    (rf_waddr_d),
      .wdata_i    (rf_wdata_d),
      .ra_addr_i  (ra_q),
      .ra_data_o  (rf_a),
      .rb_addr_i  (rb_q),
      .rb_data_o  (rf_b),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         fs_q       <= '0;
         rd_q       <= '0;
         ra_q       <= '0;
         rb_q       <= '0;
         alu_fs_q   <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         res_tmp_q  <= '0;
         zero_tmp_q <= 1'b0;
         done_q     <= 1'b0;
         res_data_q <= '0;
         zero_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept_d) begin
                  fs_q    <= req.cmd_fs;
                  rd_q    <= req.cmd_rd;
                  ra_q    <= req.cmd_ra;
                  rb_q    <= req.cmd_rb;
                  state_q <= ST_READ;
               end
            end
            // ALU operands only move here, so they stay steady between commands
            ST_READ: begin
               alu_fs_q <= fs_q;
               alu_a_q  <= rf_a;
               alu_b_q  <= rf_b;
               state_q  <= ST_EXEC;
            end
            ST_EXEC: begin
               res_tmp_q  <= alu_out;
               zero_tmp_q <= alu_zero;
               state_q    <= ST_WB;
            end
            ST_WB: begin
               res_data_q <= res_tmp_q;
               zero_q     <= zero_tmp_q;
               done_q     <= 1'b1;
               state_q    <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign alu_fs   = alu_fs_q;
   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign done     = done_q;
   assign res_data = res_data_q;
   assign zero     = zero_q;

endmodule
